// File: rtl/bp_fpga_host_pkg.sv
// Shared definitions for the host-side NBF transmit path: default field widths,
// the NBF packet layout, width helpers and the transmit arbiter state encoding.
package bp_fpga_host_pkg;

    localparam int nbf_opcode_width_gp = 8;
    localparam int nbf_addr_width_gp   = 40;
    localparam int nbf_data_width_gp   = 64;
    localparam int uart_data_bits_gp   = 8;

    // Opcode sits in the least significant byte so it is the first byte on the wire.
    typedef struct packed {
        logic [nbf_data_width_gp-1:0]   data;
        logic [nbf_addr_width_gp-1:0]   addr;
        logic [nbf_opcode_width_gp-1:0] opcode;
    } bp_fpga_host_nbf_s;

    // Total packet width for a given address/data geometry.
    function automatic int nbf_width_f(input int addr_width, input int data_width);
        return nbf_opcode_width_gp + addr_width + data_width;
    endfunction

    // Number of UART bytes a packet occupies (width must divide evenly).
    function automatic int nbf_bytes_f(input int nbf_width, input int byte_bits);
        return nbf_width / byte_bits;
    endfunction

    // Counter width able to index every byte of a packet, never narrower than one bit.
    function automatic int nbf_count_width_f(input int nbf_bytes);
        return (nbf_bytes > 1) ? $clog2(nbf_bytes) : 1;
    endfunction

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_send = 1'b1
    } nbf_tx_state_e;

endpackage

// File: rtl/fpga_host_nbf_piso.sv
// Parallel-in / serial-out stage: loads a whole packet, then presents it one byte at a
// time (least significant byte first) on a valid/ready_and interface. The byte counter
// marks the final byte so the owner knows when the packet has fully left.
module fpga_host_nbf_piso
    import bp_fpga_host_pkg::*;
#(
    parameter int  width_p      = 112,
    parameter int  byte_bits_p  = 8,
    localparam int bytes_lp     = nbf_bytes_f(width_p, byte_bits_p),
    localparam int count_w_lp   = nbf_count_width_f(bytes_lp)
)(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   v_i,
    input  logic                   ready_and_i,
    output logic [byte_bits_p-1:0] data_o,
    output logic                   v_o,
    output logic                   last_o,
    output logic                   done_o
);

    logic [width_p-1:0]    r_shift;
    logic [width_p-1:0]    w_shifted;
    logic [count_w_lp-1:0] r_count;
    logic                  w_fire;
    logic                  w_last;

    // Byte-lane view of the right shift: every lane takes its upper neighbour and the
    // top lane fills with zeros, so an emptied register reads back as all zeros.
    for (genvar gi = 0; gi < bytes_lp; gi++) begin : g_lane
        if (gi == bytes_lp - 1) begin : g_top
            assign w_shifted[gi*byte_bits_p +: byte_bits_p] = '0;
        end else begin : g_mid
            assign w_shifted[gi*byte_bits_p +: byte_bits_p] =
                r_shift[(gi+1)*byte_bits_p +: byte_bits_p];
        end
    end

    assign w_fire = v_i & ready_and_i;
    assign w_last = (r_count == count_w_lp'(bytes_lp - 1));

    // Packet register: load on accept, advance one byte per handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_shift <= '0;
        end else if (load_i) begin
            r_shift <= data_i;
        end else if (w_fire) begin
            r_shift <= w_shifted;
        end
    end

    // Byte counter: cleared on load, saturates at the final byte instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= '0;
        end else if (w_fire && !w_last) begin
            r_count <= r_count + count_w_lp'(1);
        end
    end

    assign data_o = r_shift[byte_bits_p-1:0];
    assign v_o    = v_i;
    assign last_o = w_last;
    assign done_o = w_fire & w_last;

endmodule

// File: rtl/fpga_host_nbf_tx_arbiter.sv
// Two-source NBF packet arbiter in front of the host UART transmitter. Whole packets
// are granted round-robin and serialized byte by byte; once a packet is accepted no
// other source is admitted until its last byte has been taken by the UART.
module fpga_host_nbf_tx_arbiter
    import bp_fpga_host_pkg::*;
#(
    parameter int  nbf_addr_width_p = 40,
    parameter int  nbf_data_width_p = 64,
    parameter int  uart_data_bits_p = 8,
    localparam int nbf_width_lp     = nbf_width_f(nbf_addr_width_p, nbf_data_width_p),
    localparam int nbf_bytes_lp     = nbf_bytes_f(nbf_width_lp, uart_data_bits_p)
)(
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [nbf_width_lp-1:0]     req0_nbf_i,
    input  logic                        req0_v_i,
    output logic                        req0_ready_and_o,
    input  logic [nbf_width_lp-1:0]     req1_nbf_i,
    input  logic                        req1_v_i,
    output logic                        req1_ready_and_o,
    output logic [uart_data_bits_p-1:0] tx_o,
    output logic                        tx_v_o,
    input  logic                        tx_ready_and_i,
    output logic                        busy_o,
    output logic                        grant_o
);

    // A packet that does not split into whole UART bytes cannot be serialized.
    if ((nbf_width_lp % uart_data_bits_p) != 0) begin : g_width_check
        $error("NBF packet width must be a multiple of the UART byte width");
    end

    localparam int num_req_lp = 2;

    nbf_tx_state_e             r_state;
    nbf_tx_state_e             w_state_next;
    logic                      r_grant;
    logic                      w_winner;
    logic                      w_accept;
    logic                      w_idle;
    logic                      w_send;
    logic                      w_piso_done;
    logic                      w_piso_last;
    logic [num_req_lp-1:0]     w_req_v;
    logic [num_req_lp-1:0]     w_ready;
    logic [nbf_width_lp-1:0]   w_req_nbf [num_req_lp];
    logic [nbf_width_lp-1:0]   w_load_nbf;

    assign w_req_v      = {req1_v_i, req0_v_i};
    assign w_req_nbf[0] = req0_nbf_i;
    assign w_req_nbf[1] = req1_nbf_i;

    assign w_idle = (r_state == e_idle);
    assign w_send = (r_state == e_send) & ~reset_i;

    // Under contention the previous loser wins; a lone requester always wins.
    assign w_winner = (&w_req_v) ? ~r_grant : w_req_v[1];

    // Only the winner sees ready, and nobody does while a packet is in flight or in reset.
    for (genvar gi = 0; gi < num_req_lp; gi++) begin : g_req
        assign w_ready[gi] = w_idle & ~reset_i & w_req_v[gi] & (w_winner == 1'(gi));
    end

    assign w_accept   = |w_ready;
    assign w_load_nbf = w_req_nbf[w_winner];

    assign req0_ready_and_o = w_ready[0];
    assign req1_ready_and_o = w_ready[1];

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: idle until a packet is accepted, send until its last byte is taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            e_idle: begin
                if (w_accept) begin
                    w_state_next = e_send;
                end
            end
            e_send: begin
                if (w_piso_done) begin
                    w_state_next = e_idle;
                end
            end
            default: begin
                w_state_next = e_idle;
            end
        endcase
    end

    // Owner of the current/last packet; resets to 1 so requester 0 wins first contention.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_grant <= 1'b1;
        end else if (w_accept) begin
            r_grant <= w_winner;
        end
    end

    fpga_host_nbf_piso #(
        .width_p     (nbf_width_lp),
        .byte_bits_p (uart_data_bits_p)
    ) u_piso (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (w_accept),
        .data_i      (w_load_nbf),
        .v_i         (w_send),
        .ready_and_i (tx_ready_and_i),
        .data_o      (tx_o),
        .v_o         (tx_v_o),
        .last_o      (w_piso_last),
        .done_o      (w_piso_done)
    );

    assign busy_o  = (r_state == e_send);
    assign grant_o = r_grant;

    // The last-byte flag is folded into done; keep it visible for debug probes.
    logic w_unused;
    assign w_unused = w_piso_last;

endmodule

// File: tb/tb_fpga_host_nbf_tx_arbiter.sv
// Directed bench for the two-source NBF transmit arbiter: single packet byte order and
// latency, round-robin alternation, UART back-pressure, late request, mid-packet reset,
// and an end-to-end serial loopback through bench UART models.
module tb_fpga_host_nbf_tx_arbiter;
    import bp_fpga_host_pkg::*;

    localparam int W  = 112;
    localparam int NB = 14;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  req0_nbf_i = '0;
    logic          req0_v_i = 1'b0;
    logic          req0_ready_and_o;
    logic [W-1:0]  req1_nbf_i = '0;
    logic          req1_v_i = 1'b0;
    logic          req1_ready_and_o;
    logic [7:0]    tx_o;
    logic          tx_v_o;
    logic          tx_ready_and_i = 1'b1;
    logic          busy_o;
    logic          grant_o;

    int checks = 0;
    int errors = 0;

    // Capture buffers filled by collect().
    logic [7:0] cap_byte [64];
    int         cap_cyc  [64];
    int         n_cap;
    int         acc_id   [8];
    int         acc_cyc  [8];
    int         n_acc;
    bit         stable_ok;
    bit         leak;

    always #5 clk = ~clk;

    fpga_host_nbf_tx_arbiter dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req0_nbf_i       (req0_nbf_i),
        .req0_v_i         (req0_v_i),
        .req0_ready_and_o (req0_ready_and_o),
        .req1_nbf_i       (req1_nbf_i),
        .req1_v_i         (req1_v_i),
        .req1_ready_and_o (req1_ready_and_o),
        .tx_o             (tx_o),
        .tx_v_o           (tx_v_o),
        .tx_ready_and_i   (tx_ready_and_i),
        .busy_o           (busy_o),
        .grant_o          (grant_o)
    );

    function automatic logic [W-1:0] mk(input logic [7:0] op, input logic [39:0] a,
                                        input logic [63:0] d);
        bp_fpga_host_nbf_s s;
        s.opcode = op;
        s.addr   = a;
        s.data   = d;
        return s;
    endfunction

    // Cycle-by-cycle driver/monitor. Cycle c starts at a falling edge; inputs change
    // there and outputs are sampled 1 time unit later, ahead of the deciding rising edge.
    task automatic collect(input int nbytes, input bit stall, input bit hold,
                           input bit start0, input logic [W-1:0] pkt0,
                           input int v1_cycle, input logic [W-1:0] pkt1);
        bit drop0, drop1, prev_stall;
        logic [7:0] prev_b;
        drop0 = 0; drop1 = 0; prev_stall = 0; prev_b = '0;
        n_cap = 0; n_acc = 0; stable_ok = 1; leak = 0;
        for (int c = 0; c < 600 && n_cap < nbytes; c++) begin
            @(negedge clk);
            if (drop0) req0_v_i = 1'b0;
            if (drop1) req1_v_i = 1'b0;
            drop0 = 0; drop1 = 0;
            if (start0 && c == 0) begin req0_v_i = 1'b1; req0_nbf_i = pkt0; end
            if (c == v1_cycle) begin req1_v_i = 1'b1; req1_nbf_i = pkt1; end
            tx_ready_and_i = stall ? (c % 2 == 0) : 1'b1;
            #1;
            if (prev_stall && (tx_v_o !== 1'b1 || tx_o !== prev_b)) stable_ok = 0;
            if (busy_o && (req0_ready_and_o || req1_ready_and_o)) leak = 1;
            if (req0_v_i && req0_ready_and_o && n_acc < 8) begin
                acc_id[n_acc] = 0; acc_cyc[n_acc] = c; n_acc++;
                $display("accept req0 cycle %0d opcode %02h", c, req0_nbf_i[7:0]);
                if (!hold) drop0 = 1;
            end
            if (req1_v_i && req1_ready_and_o && n_acc < 8) begin
                acc_id[n_acc] = 1; acc_cyc[n_acc] = c; n_acc++;
                $display("accept req1 cycle %0d opcode %02h", c, req1_nbf_i[7:0]);
                if (!hold) drop1 = 1;
            end
            if (tx_v_o && tx_ready_and_i) begin
                cap_byte[n_cap] = tx_o; cap_cyc[n_cap] = c; n_cap++;
            end
            prev_stall = tx_v_o && !tx_ready_and_i;
            prev_b     = tx_o;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        req0_v_i = 1'b1; req1_v_i = 1'b1;
        #1;
        checks++; if (req0_ready_and_o !== 1'b0 || req1_ready_and_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b%b want 00", req0_ready_and_o, req1_ready_and_o); end
        checks++; if (tx_v_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_tx_v_busy got %b%b want 00", tx_v_o, busy_o); end
        checks++; if (grant_o !== 1'b1) begin
            errors++; $display("FAIL reset_grant got %b want 1", grant_o); end
        checks++; if (tx_o !== 8'h00) begin
            errors++; $display("FAIL reset_tx_o got %02h want 00", tx_o); end
        @(negedge clk);
        reset_i = 1'b0; req0_v_i = 1'b0; req1_v_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || grant_o !== 1'b1) begin
            errors++; $display("FAIL post_reset got busy %b grant %b want 0 1", busy_o, grant_o); end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [NB];
        exp_b = '{8'hFF, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF,
                  8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        collect(NB, 0, 0, 1, mk(8'hFF, 40'h12_3456_789A, 64'h0123_4567_89AB_CDEF), -1, '0);
        checks++; if (n_acc !== 1 || acc_id[0] !== 0 || acc_cyc[0] !== 0) begin
            errors++; $display("FAIL single_accept got n %0d id %0d cyc %0d want 1 0 0", n_acc, acc_id[0], acc_cyc[0]); end
        checks++; if (n_cap !== NB) begin
            errors++; $display("FAIL single_count got %0d want %0d", n_cap, NB); end
        for (int k = 0; k < NB; k++) begin
            checks++; if (cap_byte[k] !== exp_b[k] || cap_cyc[k] !== k + 1) begin
                errors++; $display("FAIL single_byte%0d got %02h at cycle %0d want %02h at cycle %0d",
                                   k, cap_byte[k], cap_cyc[k], exp_b[k], k + 1); end
        end
        checks++; if (leak !== 1'b0) begin
            errors++; $display("FAIL single_ready_while_busy got 1 want 0"); end
        @(negedge clk); #1;
        checks++; if (tx_v_o !== 1'b0 || busy_o !== 1'b0 || grant_o !== 1'b0) begin
            errors++; $display("FAIL single_end got v %b busy %b grant %b want 0 0 0", tx_v_o, busy_o, grant_o); end
    endtask

    task automatic test_stall();
        logic [W-1:0] p, got;
        p = mk(8'hFF, 40'h12_3456_789A, 64'h0123_4567_89AB_CDEF);
        got = '0;
        collect(NB, 1, 0, 1, p, -1, '0);
        for (int k = 0; k < NB; k++) got[8*k +: 8] = cap_byte[k];
        checks++; if (n_cap !== NB || got !== p) begin
            errors++; $display("FAIL stall_bytes got %0d bytes %h want %0d bytes %h", n_cap, got, NB, p); end
        checks++; if (cap_cyc[NB-1] !== 28) begin
            errors++; $display("FAIL stall_duration got last byte cycle %0d want 28", cap_cyc[NB-1]); end
        checks++; if (stable_ok !== 1'b1) begin
            errors++; $display("FAIL stall_hold got unstable tx_o/tx_v want stable"); end
        tx_ready_and_i = 1'b1;
        @(negedge clk); #1;
        checks++; if (tx_v_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL stall_end got v %b busy %b want 0 0", tx_v_o, busy_o); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] pa, pb, got, want;
        pa = mk(8'hA0, 40'hA0_0000_0001, 64'hAAAA_0000_1111_2222);
        pb = mk(8'hB1, 40'hB1_0000_0002, 64'hBBBB_3333_4444_5555);
        @(negedge clk); reset_i = 1'b1;
        @(negedge clk); reset_i = 1'b0;
        collect(4 * NB, 0, 1, 1, pa, 0, pb);
        @(negedge clk); req0_v_i = 1'b0; req1_v_i = 1'b0;
        checks++; if (n_acc !== 4 || n_cap !== 4 * NB) begin
            errors++; $display("FAIL rr_counts got acc %0d bytes %0d want 4 %0d", n_acc, n_cap, 4 * NB); end
        for (int k = 0; k < 4; k++) begin
            got  = '0;
            want = (k % 2 == 0) ? pa : pb;
            for (int j = 0; j < NB; j++) got[8*j +: 8] = cap_byte[NB*k + j];
            checks++; if (acc_id[k] !== k % 2 || acc_cyc[k] !== 15 * k) begin
                errors++; $display("FAIL rr_grant%0d got req%0d cycle %0d want req%0d cycle %0d",
                                   k, acc_id[k], acc_cyc[k], k % 2, 15 * k); end
            checks++; if (got !== want) begin
                errors++; $display("FAIL rr_packet%0d got %h want %h", k, got, want); end
            checks++; if (cap_cyc[NB*k] !== 15 * k + 1 || cap_cyc[NB*k + NB - 1] !== 15 * k + NB) begin
                errors++; $display("FAIL rr_contig%0d got cycles %0d..%0d want %0d..%0d", k,
                                   cap_cyc[NB*k], cap_cyc[NB*k + NB - 1], 15 * k + 1, 15 * k + NB); end
        end
    endtask

    task automatic test_late_request();
        logic [W-1:0] p0, p1, g0, g1;
        p0 = mk(8'h11, 40'h01_0203_0405, 64'h1111_2222_3333_4444);
        p1 = mk(8'h22, 40'h0A_0B0C_0D0E, 64'h5555_6666_7777_8888);
        g0 = '0; g1 = '0;
        collect(2 * NB, 0, 0, 1, p0, 6, p1);
        for (int j = 0; j < NB; j++) begin
            g0[8*j +: 8] = cap_byte[j];
            g1[8*j +: 8] = cap_byte[NB + j];
        end
        checks++; if (n_acc !== 2 || acc_id[1] !== 1 || acc_cyc[1] !== 15) begin
            errors++; $display("FAIL late_accept got n %0d id %0d cycle %0d want 2 1 15", n_acc, acc_id[1], acc_cyc[1]); end
        checks++; if (leak !== 1'b0) begin
            errors++; $display("FAIL late_ready_while_busy got 1 want 0"); end
        checks++; if (cap_cyc[NB] !== 16) begin
            errors++; $display("FAIL late_first_byte got cycle %0d want 16", cap_cyc[NB]); end
        checks++; if (g0 !== p0 || g1 !== p1) begin
            errors++; $display("FAIL late_packets got %h %h want %h %h", g0, g1, p0, p1); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] p0, p1, g;
        p0 = mk(8'h33, 40'hCA_FE00_BEEF, 64'hDEAD_BEEF_0BAD_F00D);
        p1 = mk(8'h44, 40'h98_7654_3210, 64'hFEDC_BA98_7654_3210);
        g = '0;
        collect(8, 0, 0, 1, p0, -1, '0);
        for (int j = 0; j < 8; j++) g[8*j +: 8] = cap_byte[j];
        checks++; if (n_cap !== 8 || g[63:0] !== p0[63:0] || grant_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_prefix got %0d bytes %h grant %b want 8 %h 0", n_cap, g[63:0], grant_o, p0[63:0]); end
        @(negedge clk); reset_i = 1'b1; #1;
        checks++; if (tx_v_o !== 1'b0 || req0_ready_and_o !== 1'b0 || req1_ready_and_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_during got v %b rdy %b%b want 0 00", tx_v_o, req0_ready_and_o, req1_ready_and_o); end
        @(negedge clk); reset_i = 1'b0; #1;
        checks++; if (tx_v_o !== 1'b0 || busy_o !== 1'b0 || grant_o !== 1'b1 || tx_o !== 8'h00) begin
            errors++; $display("FAIL rst_mid_after got v %b busy %b grant %b tx %02h want 0 0 1 00",
                               tx_v_o, busy_o, grant_o, tx_o); end
        g = '0;
        collect(NB, 0, 0, 0, '0, 0, p1);
        for (int j = 0; j < NB; j++) g[8*j +: 8] = cap_byte[j];
        checks++; if (n_acc !== 1 || acc_id[0] !== 1 || cap_cyc[0] !== 1 || cap_byte[0] !== 8'h44) begin
            errors++; $display("FAIL rst_mid_next_start got acc %0d id %0d cycle %0d byte %02h want 1 1 1 44",
                               n_acc, acc_id[0], cap_cyc[0], cap_byte[0]); end
        checks++; if (n_cap !== NB || g !== p1) begin
            errors++; $display("FAIL rst_mid_next_packet got %0d bytes %h want %0d %h", n_cap, g, NB, p1); end
    endtask

    // Bench UART transmitter (2 clocks per bit, 8N1) feeding a bench UART receiver.
    task automatic test_loopback();
        logic [W-1:0] pk [2];
        logic [W-1:0] g;
        logic [9:0]   frame;
        logic [7:0]   rx_byte;
        logic [7:0]   rx_q [$];
        int           order [2];
        int           n_ord, tx_cnt, rx_ph;
        bit           rx_active, drop0, drop1;
        logic         line;
        pk[0] = mk(8'h80, 40'h00_0000_1000, 64'h0000_0000_0000_0001);
        pk[1] = mk(8'h80, 40'h00_0000_2000, 64'hFFFF_0000_FFFF_0002);
        frame = '0; rx_byte = '0; n_ord = 0; tx_cnt = 0; rx_ph = 0;
        rx_active = 0; drop0 = 0; drop1 = 0; line = 1'b1;
        for (int c = 0; c < 1500 && rx_q.size() < 2 * NB; c++) begin
            @(negedge clk);
            if (drop0) req0_v_i = 1'b0;
            if (drop1) req1_v_i = 1'b0;
            drop0 = 0; drop1 = 0;
            if (c == 0) begin
                req0_v_i = 1'b1; req0_nbf_i = pk[0];
                req1_v_i = 1'b1; req1_nbf_i = pk[1];
            end
            if (tx_cnt > 0) begin
                line = frame[(20 - tx_cnt) / 2]; tx_cnt--; tx_ready_and_i = 1'b0;
            end else begin
                line = 1'b1; tx_ready_and_i = 1'b1;
            end
            #1;
            if (req0_v_i && req0_ready_and_o && n_ord < 2) begin order[n_ord] = 0; n_ord++; drop0 = 1; end
            if (req1_v_i && req1_ready_and_o && n_ord < 2) begin order[n_ord] = 1; n_ord++; drop1 = 1; end
            if (tx_cnt == 0 && tx_ready_and_i && tx_v_o) begin
                frame = {1'b1, tx_o, 1'b0}; tx_cnt = 20;
            end
            if (rx_active) begin
                rx_ph++;
                if (rx_ph % 2 == 1 && rx_ph >= 3 && rx_ph <= 17) rx_byte[(rx_ph - 3) / 2] = line;
                if (rx_ph == 19) begin rx_q.push_back(rx_byte); rx_active = 0; end
            end else if (line == 1'b0) begin
                rx_active = 1; rx_ph = 0;
            end
        end
        tx_ready_and_i = 1'b1;
        checks++; if (rx_q.size() !== 2 * NB || n_ord !== 2) begin
            errors++; $display("FAIL loop_counts got %0d bytes %0d packets want %0d 2", rx_q.size(), n_ord, 2 * NB); end
        for (int k = 0; k < 2; k++) begin
            g = '0;
            for (int j = 0; j < NB && (NB*k + j) < rx_q.size(); j++) g[8*j +: 8] = rx_q[NB*k + j];
            checks++; if (g !== pk[order[k]]) begin
                errors++; $display("FAIL loop_packet%0d got %h want %h", k, g, pk[order[k]]); end
            $display("loopback packet %0d from req%0d received %h", k, order[k], g);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_round_robin();
        test_late_request();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation timed out");
    end

endmodule
